divider_seq: RTL and testbench

Multi-cycle 32-bit integer divider for the EX stage, the counterpart of the pipelined multiplier. It accepts the same operand bundle (`sign`, `srca`, `srcb`) and returns `lo` = quotient, `hi` = remainder, matching MIPS DIV/DIVU HI/LO semantics. The divider is a radix-2 restoring divider that resolves one quotient bit per cycle. It uses the multiplier's hold-until-valid handshake, so the EX-stage stall logic treats both units identically.

---
 rtl/div_pkg.sv | 16 +
 rtl/divider_seq_if.sv | 23 ++
 rtl/divider_seq.sv | 145 ++++++++++++++
 tb/tb_divider_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Magnitude on 33 bits so that |0x80000000| stays exact.
  function automatic logic [DIV_W:0] abs33(input logic sgn, input logic [DIV_W-1:0] v);
    logic [DIV_W:0] x;
    x = {sgn & v[DIV_W-1], v};
    return x[DIV_W] ? -x : x;
  endfunction

endpackage

// File: rtl/divider_seq_if.sv
// Request/response bundle between the EX stage and the sequential divider.
interface divider_seq_if;
  import div_pkg::*;

  logic             in_valid;
  logic             sign;
  logic [DIV_W-1:0] srca;
  logic [DIV_W-1:0] srcb;
  logic             out_valid;
  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] lo;

  modport master (
    output in_valid, sign, srca, srcb,
    input  out_valid, hi, lo
  );

  modport slave (
    input  in_valid, sign, srca, srcb,
    output out_valid, hi, lo
  );

endinterface

// File: rtl/divider_seq.sv
// Radix-2 restoring divider, one quotient bit per cycle; lo = quotient, hi = remainder.
// Operands are held with in_valid until out_valid; any change restarts the operation.
module divider_seq
  import div_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  divider_seq_if.slave bus
);

  div_state_t       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [DIV_W-1:0] srca_q, srca_d;
  logic [DIV_W-1:0] srcb_q, srcb_d;
  logic [DIV_W-1:0] dvd_q, dvd_d;
  logic [DIV_W:0]   dsr_q, dsr_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             out_valid_q, out_valid_d;
  logic [DIV_W-1:0] hi_q, hi_d;
  logic [DIV_W-1:0] lo_q, lo_d;

  logic             match, load, ge;
  logic [DIV_W:0]   rem_sh, rem_nx, a_abs, b_abs;
  logic [DIV_W-1:0] quo_nx;
  logic             unused_bits;

  assign unused_bits = ^{a_abs[DIV_W], rem_nx[DIV_W]};

  always_comb begin
    match  = ({bus.sign, bus.srca, bus.srcb} == {sign_q, srca_q, srcb_q});
    a_abs  = abs33(bus.sign, bus.srca);
    b_abs  = abs32_ext();
    rem_sh = {rem_q, dvd_q[DIV_W-1]};
    ge     = (rem_sh >= dsr_q);
    rem_nx = ge ? (rem_sh - dsr_q) : rem_sh;
    // Quotient bits shift into the dividend register as its bits shift out.
    quo_nx = {dvd_q[DIV_W-2:0], ge};

    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    out_valid_d = out_valid_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) load = 1'b1;
      end
      CALC: begin
        if (!bus.in_valid) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (!match) begin
          load = 1'b1;
        end else begin
          rem_d = rem_nx[DIV_W-1:0];
          dvd_d = quo_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_ITERS - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            lo_d        = (srcb_q == '0) ? '1 : (neg_q_q ? -quo_nx : quo_nx);
            hi_d        = neg_r_q ? -rem_nx[DIV_W-1:0] : rem_nx[DIV_W-1:0];
          end
        end
      end
      DONE: begin
        if (!bus.in_valid) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (!match) begin
          load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d     = CALC;
      cnt_d       = '0;
      sign_d      = bus.sign;
      srca_d      = bus.srca;
      srcb_d      = bus.srcb;
      dvd_d       = a_abs[DIV_W-1:0];
      dsr_d       = b_abs;
      rem_d       = '0;
      neg_q_d     = bus.sign & (bus.srca[DIV_W-1] ^ bus.srcb[DIV_W-1]);
      neg_r_d     = bus.sign & bus.srca[DIV_W-1];
      out_valid_d = 1'b0;
    end
  end

  function automatic logic [DIV_W:0] abs32_ext();
    return abs33(bus.sign, bus.srcb);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      srca_q      <= '0;
      srcb_q      <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_divider_seq.sv
// Randomised scoreboard bench for divider_seq against a plain-arithmetic DIV/DIVU model.
module tb_divider_seq;

  logic clk;
  logic rst_n;
  divider_seq_if bus ();

  divider_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Result packed as {lo, hi}.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sign     = s;
    bus.srca     = a;
    bus.srcb     = b;
    if (push) begin
      last_exp = model(s, a, b);
      exp_q.push_back(last_exp);
    end
  endtask

  // Caller has just driven a request; the next edge is E0.
  task automatic wait_out();
    int n;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.out_valid && n < 40);
    check("latency", 64'(n), 64'd32);
  endtask

  task automatic drop();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b);
    start(s, a, b, 1'b1);
    wait_out();
  endtask

  // Monitor: every rising out_valid must match the oldest outstanding expectation.
  initial begin
    logic ov_prev;
    logic [63:0] e;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !ov_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %h with no request outstanding", {bus.lo, bus.hi});
        end else begin
          e = exp_q.pop_front();
          check("result", {bus.lo, bus.hi}, e);
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  initial begin
    logic        s, ps;
    logic [31:0] a, b, pa, pb;
    bus.in_valid = 1'b0;
    bus.sign     = 1'b0;
    bus.srca     = '0;
    bus.srcb     = '0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_state", {31'd0, bus.out_valid, bus.lo}, 64'd0);
    check("reset_hi", {32'd0, bus.hi}, 64'd0);

    run(1'b0, 32'd100, 32'd7);
    drop();
    run(1'b1, 32'hFFFF_FFF9, 32'd2);
    run(1'b0, 32'hFFFF_FFF9, 32'd2);          // back-to-back, differing sign
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b0, 32'd5, 32'd0);
    run(1'b1, 32'hFFFF_FFF0, 32'd0);
    drop();

    // Abort: change srca ten cycles into CALC.
    start(1'b0, 32'd100, 32'd7, 1'b0);
    @(posedge clk);
    repeat (10) @(posedge clk);
    start(1'b0, 32'd50, 32'd7, 1'b1);
    wait_out();
    drop();

    // Drop mid-CALC keeps the previous result visible.
    start(1'b0, 32'd1000, 32'd9, 1'b0);
    repeat (5) @(posedge clk);
    drop();
    repeat (3) @(posedge clk);
    #1;
    check("drop_valid", {63'd0, bus.out_valid}, 64'd0);
    check("drop_hold", {bus.lo, bus.hi}, last_exp);
    run(1'b0, 32'd1000, 32'd9);
    drop();

    // Asynchronous reset mid-CALC.
    start(1'b1, 32'hFFFF_FF00, 32'd3, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.lo, bus.hi}, 64'd0);
    check("async_reset_valid", {63'd0, bus.out_valid}, 64'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 32'd9, 32'd3);
    drop();

    ps = 1'b0; pa = '0; pb = '0;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: a = $urandom_range(0, 50);
        4: b = -($urandom_range(1, 20));
        default: ;
      endcase
      if (({s, a, b} == {ps, pa, pb}) || ($urandom_range(0, 1) == 1)) drop();
      run(s, a, b);
      ps = s; pa = a; pb = b;
    end
    drop();

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
